// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types and helpers for the fifo round-robin drain arbiter.
package arb_pkg;

  // Output-register occupancy: IDLE = empty, HOLD = a word is presented.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Successor of idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: picks the first requester
// strictly after i_last, wrapping around the ring.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_gnt_onehot,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_gnt_any
);

  // One extra bit so start+offset never wraps before the modulo reduction,
  // which keeps non-power-of-2 rings correct.
  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(NUM_REQ);

  logic [IDX_W:0] w_start;
  logic [IDX_W:0] w_cand;

  assign w_start = (IDX_W + 1)'(rr_next(int'(i_last), NUM_REQ));

  // Scan the ring from the slot after the last grant; first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned (no latch); blocking '=' is correct in combinational code.
    o_gnt_onehot = '0;
    o_gnt_idx    = '0;
    o_gnt_any    = 1'b0;
    w_cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = w_start + (IDX_W + 1)'(k);
      if (w_cand >= N_W) w_cand = w_cand - N_W;
      if (!o_gnt_any && i_req[w_cand[IDX_W-1:0]]) begin
        o_gnt_onehot[w_cand[IDX_W-1:0]] = 1'b1;
        o_gnt_idx                       = w_cand[IDX_W-1:0];
        o_gnt_any                       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Drain stage for a bank of fifos: round-robin pops one non-empty fifo per
// cycle into a 1-deep output register presented on a valid/ready port.
module fifo_rr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_fifo_empty,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_fifo_dout,
  output logic [NUM_REQ-1:0]            o_fifo_pop,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [DATA_WIDTH-1:0]         o_out_data,
  output logic [IDX_W-1:0]              o_out_src
);

  arb_state_e            r_state;
  arb_state_e            w_state_next;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [IDX_W-1:0]      r_out_src;
  logic [IDX_W-1:0]      r_last_grant;

  logic                  w_can_load;
  logic                  w_handshake;
  logic [NUM_REQ-1:0]    w_req;
  logic [NUM_REQ-1:0]    w_gnt_onehot;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_gnt_any;
  logic                  w_grant;

  // The output register can take a word when it is empty or draining now.
  assign w_can_load  = (r_state == IDLE) || i_out_ready;
  assign w_handshake = (r_state == HOLD) && i_out_ready;
  assign w_req       = w_can_load ? ~i_fifo_empty : '0;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req        (w_req),
    .i_last       (r_last_grant),
    .o_gnt_onehot (w_gnt_onehot),
    .o_gnt_idx    (w_gnt_idx),
    .o_gnt_any    (w_gnt_any)
  );

  // Pops are suppressed while reset is held so no word is lost upstream.
  assign w_grant     = w_gnt_any && !i_rst;
  assign o_fifo_pop  = w_grant ? w_gnt_onehot : '0;
  assign o_out_valid = (r_state == HOLD);
  assign o_out_data  = r_out_data;
  assign o_out_src   = r_out_src;

  // State register: tracks whether the output register holds a word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking '<=' so all flops update
    // together from pre-edge values.
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic: load keeps HOLD, a drain without refill returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (w_grant) w_state_next = HOLD;
      HOLD: if (w_handshake && !w_grant) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Capture the popped word, its source and the new round-robin pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_data   <= '0;
      r_out_src    <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (w_grant) begin
      r_out_data   <= i_fifo_dout[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      r_out_src    <= w_gnt_idx;
      r_last_grant <= w_gnt_idx;
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter (NUM_REQ=4, DATA_WIDTH=4) plus a
// randomized phase checking pop legality, data capture and fairness.
module tb_fifo_rr_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] empty = '1;
  logic [N*W-1:0] dout = 16'hBA98;
  logic [N-1:0] pop;
  logic         valid;
  logic         ready = 1'b0;
  logic [W-1:0] data;
  logic [1:0]   src;

  int total = 0;
  int bad   = 0;

  fifo_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_fifo_empty (empty),
    .i_fifo_dout  (dout),
    .o_fifo_pop   (pop),
    .o_out_valid  (valid),
    .i_out_ready  (ready),
    .o_out_data   (data),
    .o_out_src    (src)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after a rising edge, then wait to the falling edge
  // where combinational pop and registered outputs are both settled.
  task automatic step(input logic [N-1:0] e, input logic r, input logic [N*W-1:0] d);
    @(posedge clk);
    #1;
    empty = e;
    ready = r;
    dout  = d;
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [W-1:0] d,
                         input logic [1:0] s, input logic [N-1:0] p);
    check({tag, ".valid"}, 32'(valid), 32'(v));
    if (v) begin
      check({tag, ".data"}, 32'(data), 32'(d));
      check({tag, ".src"},  32'(src),  32'(s));
    end
    check({tag, ".pop"}, 32'(pop), 32'(p));
  endtask

  localparam logic [N*W-1:0] D0 = 16'hBA98;  // dout[i] = i + 8

  logic         m_valid;
  logic [W-1:0] m_data;
  logic [1:0]   m_src;
  int           cnt [N];
  logic         can_load;
  int           gidx;

  initial begin
    // 1. Reset: pops forced low even with requests, outputs cleared.
    empty = '0;
    ready = 1'b1;
    #3;
    check("rst.pop", 32'(pop), 32'h0);
    check("rst.valid", 32'(valid), 32'h0);
    check("rst.data", 32'(data), 32'h0);
    check("rst.src", 32'(src), 32'h0);
    @(posedge clk);
    #1;
    empty = '1;
    rst   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, 1'b1, D0);
      check("idle.pop", 32'(pop), 32'h0);
      check("idle.valid", 32'(valid), 32'h0);
    end

    // 2. All non-empty, consumer always ready: 0,1,2,3,0 back to back.
    step(4'b0000, 1'b1, D0); chk_out("rr0", 1'b0, 4'd0,  2'd0, 4'b0001);
    step(4'b0000, 1'b1, D0); chk_out("rr1", 1'b1, 4'd8,  2'd0, 4'b0010);
    step(4'b0000, 1'b1, D0); chk_out("rr2", 1'b1, 4'd9,  2'd1, 4'b0100);
    step(4'b0000, 1'b1, D0); chk_out("rr3", 1'b1, 4'd10, 2'd2, 4'b1000);
    step(4'b0000, 1'b1, D0); chk_out("rr4", 1'b1, 4'd11, 2'd3, 4'b0001);
    step(4'b1111, 1'b1, D0); chk_out("rr5", 1'b1, 4'd8,  2'd0, 4'b0000);
    step(4'b1111, 1'b1, D0); chk_out("rr6", 1'b0, 4'd8,  2'd0, 4'b0000);
    check("rr6.hold_data", 32'(data), 32'h8);
    check("rr6.hold_src", 32'(src), 32'h0);

    // 3. Only fifo 2, consumer stalls 3 cycles: one pop, word held, refill on release.
    step(4'b1011, 1'b0, D0); chk_out("bp0", 1'b0, 4'd0,  2'd0, 4'b0100);
    step(4'b1011, 1'b0, D0); chk_out("bp1", 1'b1, 4'd10, 2'd2, 4'b0000);
    step(4'b1011, 1'b0, D0); chk_out("bp2", 1'b1, 4'd10, 2'd2, 4'b0000);
    step(4'b1011, 1'b0, D0); chk_out("bp3", 1'b1, 4'd10, 2'd2, 4'b0000);
    step(4'b1011, 1'b1, 16'hB598); chk_out("bp4", 1'b1, 4'd10, 2'd2, 4'b0100);
    step(4'b1111, 1'b1, D0); chk_out("bp5", 1'b1, 4'd5,  2'd2, 4'b0000);
    step(4'b1111, 1'b1, D0); chk_out("bp6", 1'b0, 4'd5,  2'd2, 4'b0000);

    // 4. Move pointer to 3, then fifos 1 and 3 alternate (wrap + fairness).
    step(4'b0111, 1'b1, D0); chk_out("wr0", 1'b0, 4'd0,  2'd0, 4'b1000);
    step(4'b0101, 1'b1, D0); chk_out("wr1", 1'b1, 4'd11, 2'd3, 4'b0010);
    step(4'b0101, 1'b1, D0); chk_out("wr2", 1'b1, 4'd9,  2'd1, 4'b1000);
    step(4'b0101, 1'b1, D0); chk_out("wr3", 1'b1, 4'd11, 2'd3, 4'b0010);
    step(4'b1111, 1'b1, D0); chk_out("wr4", 1'b1, 4'd9,  2'd1, 4'b0000);
    step(4'b1111, 1'b1, D0); chk_out("wr5", 1'b0, 4'd9,  2'd1, 4'b0000);

    // 5. Reset while holding a word: drop it at once; first grant to lowest index.
    step(4'b1110, 1'b1, D0); chk_out("mr0", 1'b0, 4'd0, 2'd0, 4'b0001);
    step(4'b1110, 1'b0, D0); chk_out("mr1", 1'b1, 4'd8, 2'd0, 4'b0000);
    #2;
    rst = 1'b1;
    #1;
    check("mr.valid_async", 32'(valid), 32'h0);
    check("mr.pop_in_rst", 32'(pop), 32'h0);
    check("mr.data_rst", 32'(data), 32'h0);
    empty = 4'b1010;
    ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mr.pop_in_rst2", 32'(pop), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk_out("mr2", 1'b0, 4'd0, 2'd0, 4'b0001);
    step(4'b1010, 1'b1, D0); chk_out("mr3", 1'b1, 4'd8,  2'd0, 4'b0100);
    step(4'b1111, 1'b1, D0); chk_out("mr4", 1'b1, 4'd10, 2'd2, 4'b0000);
    step(4'b1111, 1'b1, D0); chk_out("mr5", 1'b0, 4'd10, 2'd2, 4'b0000);

    // 6. Random traffic: legality, capture, work conservation, fairness.
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int n = 0; n < 1000; n++) begin
      step(N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 16'($urandom));
      check("rnd.valid", 32'(valid), 32'(m_valid));
      if (m_valid) begin
        check("rnd.data", 32'(data), 32'(m_data));
        check("rnd.src", 32'(src), 32'(m_src));
      end
      check("rnd.onehot0", 32'($onehot0(pop)), 32'h1);
      check("rnd.pop_empty", 32'(pop & empty), 32'h0);
      can_load = !m_valid || ready;
      check("rnd.work_cons", 32'(pop != 0), 32'(can_load && (empty != '1)));
      gidx = -1;
      for (int i = 0; i < N; i++) if (pop[i]) gidx = i;
      if (pop != 0) begin
        for (int i = 0; i < N; i++) begin
          if (pop[i])        cnt[i] = 0;
          else if (!empty[i]) cnt[i]++;
          else               cnt[i] = 0;
          check("rnd.fair", 32'(cnt[i] <= N - 1), 32'h1);
        end
      end
      if (gidx >= 0) begin
        m_valid = 1'b1;
        m_data  = dout[gidx*W +: W];
        m_src   = 2'(gidx);
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
